// File: rtl/sha256_block_loader_if.sv
// Host bus, block stream and digest return bundle for sha256_block_loader.
// slave: the loader's view. master: the host/core/test side driving it.
interface sha256_block_loader_if #(
    parameter int ADDR_W = 6
);
    // host memory-mapped access
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    // block stream to the compression core
    logic              blk_valid;
    logic              blk_ready;
    logic [511:0]      blk_data;
    logic              blk_first;
    logic              blk_last;
    // digest return from the core
    logic              digest_valid;
    logic [255:0]      digest_in;
    // completion interrupt
    logic              irq;

    modport slave (
        input  chipselect, write, read, address, writedata,
        input  blk_ready, digest_valid, digest_in,
        output readdata, blk_valid, blk_data, blk_first, blk_last, irq
    );

    modport master (
        output chipselect, write, read, address, writedata,
        output blk_ready, digest_valid, digest_in,
        input  readdata, blk_valid, blk_data, blk_first, blk_last, irq
    );
endinterface

// File: rtl/sha256_block_loader.sv
// Memory-mapped message buffer feeding 512-bit blocks to a SHA-256 core.
// Ports: clk, reset (sync, active-high), bus (slave: host regs, blocks, digest).
module sha256_block_loader #(
    parameter int MAX_BLOCKS = 2,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    sha256_block_loader_if.slave  bus
);
    localparam int B  = 16 * MAX_BLOCKS;
    localparam int IW = $clog2(B);

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(B);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(B + 1);
    localparam logic [ADDR_W-1:0] A_DIG0 = ADDR_W'(B + 2);
    localparam logic [ADDR_W-1:0] A_DIG7 = ADDR_W'(B + 9);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    // message buffer: deliberately not reset
    logic [31:0] mem [B];

    logic [7:0]   idx_q;
    logic [7:0]   nblk_q;
    logic         done_q;
    logic         error_q;
    logic [255:0] digest_q;
    logic [31:0]  rdata_q;
    logic [31:0]  rdata_d;

    logic host_wr, host_rd;
    logic sel_msg, sel_ctrl, sel_stat, sel_dig;
    logic busy;
    logic start_req, nblk_ok, start_ok;
    logic xfer, is_last, capture;
    logic [ADDR_W-1:0] doff;
    logic [2:0]        dsel;
    logic [IW-1:0]     base;

    assign host_wr  = bus.chipselect && bus.write;
    assign host_rd  = bus.chipselect && bus.read;
    assign sel_msg  = bus.address < A_CTRL;
    assign sel_ctrl = bus.address == A_CTRL;
    assign sel_stat = bus.address == A_STAT;
    assign sel_dig  = (bus.address >= A_DIG0) && (bus.address <= A_DIG7);
    assign doff     = bus.address - A_DIG0;
    assign dsel     = doff[2:0];

    // busy is exactly "a job is in flight"
    assign busy = state_q != S_IDLE;

    assign start_req = host_wr && sel_ctrl && bus.writedata[31];
    assign nblk_ok   = (bus.writedata[7:0] != 8'd0) &&
                       (bus.writedata[7:0] <= 8'(MAX_BLOCKS));
    assign start_ok  = (state_q == S_IDLE) && start_req && nblk_ok;

    assign xfer    = (state_q == S_SEND) && bus.blk_ready;
    assign is_last = idx_q == (nblk_q - 8'd1);
    assign capture = (state_q == S_WAIT) && bus.digest_valid;

    assign base = IW'({idx_q, 4'b0000});

    // next state and stream outputs
    always_comb begin
        state_d       = state_q;
        bus.blk_valid = 1'b0;
        bus.blk_first = 1'b0;
        bus.blk_last  = 1'b0;
        bus.blk_data  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok)
                    state_d = S_SEND;
            end
            S_SEND: begin
                bus.blk_valid = 1'b1;
                bus.blk_first = idx_q == 8'd0;
                bus.blk_last  = is_last;
                for (int k = 0; k < 16; k++)
                    bus.blk_data[511-32*k -: 32] = mem[base | IW'(k)];
                if (xfer && is_last)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (capture)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // host writes into the buffer are locked out for the whole job
    always_ff @(posedge clk) begin
        if (!reset && host_wr && sel_msg && !busy)
            mem[IW'(bus.address)] <= bus.writedata;
    end

    // read mux, registered below
    always_comb begin
        rdata_d = '0;
        unique case (1'b1)
            sel_stat: rdata_d = {29'b0, error_q, done_q, busy};
            sel_dig: begin
                for (int i = 0; i < 8; i++)
                    if (dsel == 3'(i))
                        rdata_d = digest_q[255-32*i -: 32];
            end
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q    <= '0;
            nblk_q   <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            digest_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (start_ok) begin
                nblk_q <= bus.writedata[7:0];
                idx_q  <= '0;
            end else if (xfer && !is_last) begin
                idx_q  <= idx_q + 8'd1;
            end

            if ((host_wr && sel_msg && busy) ||
                ((state_q == S_IDLE) && start_req && !nblk_ok))
                error_q <= 1'b1;
            else if (host_wr && sel_stat && bus.writedata[2])
                error_q <= 1'b0;

            // capture beats a same-cycle done clear
            if (capture)
                done_q <= 1'b1;
            else if (start_ok || (host_wr && sel_stat && bus.writedata[1]))
                done_q <= 1'b0;

            if (capture)
                digest_q <= bus.digest_in;

            if (host_rd)
                rdata_q <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign bus.irq      = done_q;

endmodule

// File: tb/tb_sha256_block_loader.sv
// Self-checking bench for sha256_block_loader: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_sha256_block_loader;
    localparam int MB = 2;
    localparam int AW = 6;
    localparam int B  = 16 * MB;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sha256_block_loader_if #(.ADDR_W(AW)) bif ();

    sha256_block_loader #(
        .MAX_BLOCKS(MB),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    // reference model state
    blk_t         q[$];
    logic [31:0]  shadow [B];
    int           mstate;
    logic         m_busy, m_done, m_err;
    logic [255:0] m_dig;
    logic [31:0]  m_rd;

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: applies each sampled edge's inputs (mstate 0 idle, 1 send, 2 wait)
    initial begin
        bit          wr, rd, b0;
        int          a, n;
        logic [31:0] wd;
        blk_t        e;
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                mstate = 0;
                m_busy = 0;
                m_done = 0;
                m_err  = 0;
                m_dig  = '0;
                m_rd   = '0;
            end else begin
                wr = bif.chipselect && bif.write;
                rd = bif.chipselect && bif.read;
                a  = int'(bif.address);
                wd = bif.writedata;
                b0 = m_busy;
                if (rd) begin
                    if (a == B + 1)
                        m_rd = {29'b0, m_err, m_done, m_busy};
                    else if (a >= B + 2 && a <= B + 9)
                        m_rd = m_dig[255-32*(a-B-2) -: 32];
                    else
                        m_rd = '0;
                end
                if (wr && a == B + 1) begin
                    if (wd[1]) m_done = 0;
                    if (wd[2]) m_err = 0;
                end
                if (mstate == 2 && bif.digest_valid) begin
                    m_dig  = bif.digest_in;
                    m_done = 1;
                    m_busy = 0;
                    mstate = 0;
                end
                if (mstate == 1 && bif.blk_ready) begin
                    q.delete(0);
                    if (q.size() == 0) mstate = 2;
                end
                if (wr && a < B) begin
                    if (b0) m_err = 1;
                    else shadow[a] = wd;
                end
                if (wr && a == B && wd[31] && !b0) begin
                    n = int'(wd[7:0]);
                    if (n >= 1 && n <= MB) begin
                        for (int b = 0; b < n; b++) begin
                            for (int w = 0; w < 16; w++)
                                e.data[511-32*w -: 32] = shadow[b*16+w];
                            e.first = (b == 0);
                            e.last  = (b == n - 1);
                            q.push_back(e);
                        end
                        m_busy = 1;
                        m_done = 0;
                        mstate = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
    end

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("readdata", bif.readdata, m_rd);
                chk("irq", bif.irq, m_done);
                chk("blk_valid", bif.blk_valid, mstate == 1);
                if (mstate == 1 && q.size() > 0) begin
                    chk("blk_data", bif.blk_data, q[0].data);
                    chk("blk_first", bif.blk_first, q[0].first);
                    chk("blk_last", bif.blk_last, q[0].last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int a, logic [31:0] d);
        bif.chipselect = 1;
        bif.write      = 1;
        bif.address    = AW'(a);
        bif.writedata  = d;
        tick();
        bif.chipselect = 0;
        bif.write      = 0;
    endtask

    task automatic rd_chk(string name, int a, logic [31:0] exp);
        bif.chipselect = 1;
        bif.read       = 1;
        bif.address    = AW'(a);
        tick();
        bif.chipselect = 0;
        bif.read       = 0;
        chk(name, bif.readdata, exp);
    endtask

    task automatic send_digest(logic [255:0] v);
        bif.digest_valid = 1;
        bif.digest_in    = v;
        tick();
        bif.digest_valid = 0;
    endtask

    logic [255:0] abc, d2, d3, d4, d6;
    logic [511:0] held;

    initial begin
        abc = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
        d2  = {32'h22220000, 32'h22220001, 32'h22220002, 32'h22220003,
               32'h22220004, 32'h22220005, 32'h22220006, 32'h22220007};
        d3  = {8{32'hbad0bad0}};
        d4  = {8{32'h44444444}};
        d6  = {32'h66660000, 32'h0, 32'h0, 32'h0,
               32'h0, 32'h0, 32'h0, 32'h6666ffff};

        bif.chipselect   = 0;
        bif.write        = 0;
        bif.read         = 0;
        bif.address      = '0;
        bif.writedata    = '0;
        bif.blk_ready    = 0;
        bif.digest_valid = 0;
        bif.digest_in    = '0;

        // reset
        reset = 1;
        repeat (3) tick();
        chk("rst_valid", bif.blk_valid, 0);
        chk("rst_first", bif.blk_first, 0);
        chk("rst_last", bif.blk_last, 0);
        chk("rst_data", bif.blk_data, 0);
        chk("rst_irq", bif.irq, 0);
        chk("rst_readdata", bif.readdata, 0);
        reset  = 0;
        mon_on = 1;
        rd_chk("rst_status", B + 1, 32'h0);
        rd_chk("rst_digest0", B + 2, 32'h0);

        // single block
        for (int k = 0; k < 16; k++)
            wr(k, (k == 0) ? 32'h61626380 : (k == 15) ? 32'h18 : 32'h0);
        bif.blk_ready = 1;
        wr(B, 32'h80000001);
        chk("s1_valid", bif.blk_valid, 1);
        chk("s1_word0", bif.blk_data[511:480], 32'h61626380);
        chk("s1_word15", bif.blk_data[31:0], 32'h18);
        chk("s1_first", bif.blk_first, 1);
        chk("s1_last", bif.blk_last, 1);
        tick();
        chk("s1_one_cycle", bif.blk_valid, 0);
        send_digest(abc);
        chk("s1_irq", bif.irq, 1);
        rd_chk("s1_status", B + 1, 32'h2);
        rd_chk("s1_digest0", B + 2, 32'hba7816bf);
        rd_chk("s1_digest7", B + 9, 32'hf20015ad);
        wr(B + 1, 32'h2);
        chk("s1_irq_clr", bif.irq, 0);

        // two blocks with backpressure
        bif.blk_ready = 0;
        for (int k = 0; k < 16; k++)
            wr(k, 32'h1000 + k);
        for (int k = 0; k < 16; k++)
            wr(16 + k, (k == 0) ? 32'hdeadbeef : 32'h2000 + k);
        wr(B, 32'h80000002);
        held = bif.blk_data;
        chk("s2_b0_word0", held[511:480], 32'h1000);
        repeat (5) begin
            chk("s2_hold_valid", bif.blk_valid, 1);
            chk("s2_hold_data", bif.blk_data, held);
            chk("s2_hold_first", bif.blk_first, 1);
            chk("s2_hold_last", bif.blk_last, 0);
            tick();
        end
        bif.blk_ready = 1;
        tick();
        chk("s2_b1_word0", bif.blk_data[511:480], 32'hdeadbeef);
        chk("s2_b1_word15", bif.blk_data[31:0], 32'h200f);
        chk("s2_b1_first", bif.blk_first, 0);
        chk("s2_b1_last", bif.blk_last, 1);
        tick();
        chk("s2_drained", bif.blk_valid, 0);
        bif.blk_ready = 0;
        send_digest(d2);
        rd_chk("s2_digest0", B + 2, 32'h22220000);
        wr(B + 1, 32'h2);

        // illegal starts
        wr(B, 32'h80000000);
        chk("s3_zero_novalid", bif.blk_valid, 0);
        rd_chk("s3_zero_status", B + 1, 32'h4);
        wr(B, 32'h80000003);
        chk("s3_big_novalid", bif.blk_valid, 0);
        rd_chk("s3_big_status", B + 1, 32'h4);
        wr(B + 1, 32'h4);
        rd_chk("s3_cleared", B + 1, 32'h0);

        // busy protection
        send_digest(d3);
        rd_chk("s4_stray_ignored", B + 2, 32'h22220000);
        bif.blk_ready = 1;
        wr(B, 32'h80000001);
        tick();
        bif.blk_ready = 0;
        wr(0, 32'h12345678);
        rd_chk("s4_err_busy", B + 1, 32'h5);
        wr(B, 32'h80000001);
        chk("s4_start_ignored", bif.blk_valid, 0);
        rd_chk("s4_err_kept", B + 1, 32'h5);
        send_digest(d4);
        rd_chk("s4_done_err", B + 1, 32'h6);
        wr(B + 1, 32'h6);
        rd_chk("s4_cleared", B + 1, 32'h0);
        bif.blk_ready = 1;
        wr(B, 32'h80000001);
        chk("s4_replay_word0", bif.blk_data[511:480], 32'h1000);
        tick();
        send_digest(d4);
        wr(B + 1, 32'h2);

        // reset mid-send
        bif.blk_ready = 0;
        wr(B, 32'h80000002);
        tick();
        tick();
        reset = 1;
        tick();
        chk("s5_valid_drop", bif.blk_valid, 0);
        reset = 0;
        rd_chk("s5_status", B + 1, 32'h0);
        rd_chk("s5_digest_rst", B + 2, 32'h0);
        bif.blk_ready = 1;
        wr(B, 32'h80000001);
        chk("s5_valid", bif.blk_valid, 1);
        chk("s5_first_last", {bif.blk_first, bif.blk_last}, 2'b11);
        tick();
        send_digest(d6);
        rd_chk("s5_status_done", B + 1, 32'h2);
        rd_chk("s5_digest7", B + 9, 32'h6666ffff);
        tick();

        mon_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
